// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared encodings for the fetch PC controller: next-PC mux select codes,
// fetch FSM state codes and the redirect priority encoder.
package fetch_pc_ctrl_pkg;

    // Select codes for the external 4:1 next-PC mux. The numeric order
    // doubles as redirect priority, so a larger code always wins.
    localparam logic [1:0] SEL_NEXT_INS = 2'b00;
    localparam logic [1:0] SEL_BRANCH   = 2'b01;
    localparam logic [1:0] SEL_JUMP     = 2'b10;
    localparam logic [1:0] SEL_ZERO     = 2'b11;

    localparam logic [1:0] ST_REQ  = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] ZERO_PC          = 32'h0000_0000;

    function automatic logic [1:0] redirect_code(
        input logic zero,
        input logic jump,
        input logic branch
    );
        if (zero)
            return SEL_ZERO;
        if (jump)
            return SEL_JUMP;
        if (branch)
            return SEL_BRANCH;
        return SEL_NEXT_INS;
    endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Instruction-memory request/grant/response and decode valid/ready signals
// seen by the fetch PC controller.
interface fetch_pc_ctrl_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready
    );

endinterface

// File: rtl/fetch_pc_ctrl_redirect_arbiter.sv
// Latches redirect pulses by priority, drives the next-PC select code and
// flags in-flight fetches whose response must be thrown away.
module fetch_pc_ctrl_redirect_arbiter
    import fetch_pc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       redir_zero,
    input  logic       redir_jump,
    input  logic       redir_branch,
    input  logic [1:0] state,
    input  logic       imem_gnt,
    input  logic       imem_rvalid,
    input  logic       accept,
    output logic [1:0] pc_sel,
    output logic       redirect_now,
    output logic       kill
);

    logic [1:0] pending;
    logic [1:0] pulse_code;
    logic [1:0] pending_base;
    logic [1:0] pending_next;

    // Outside HOLD a pending redirect is applied immediately; in HOLD it
    // waits for decode to accept the held instruction.
    assign redirect_now = (pending != SEL_NEXT_INS) && (state != ST_HOLD);
    assign pc_sel       = pending;

    // NOTE: every always_comb output gets a default first so no path can hold an old value and infer a latch.
    always_comb begin
        pulse_code   = redirect_code(redir_zero, redir_jump, redir_branch);
        pending_base = (accept || redirect_now) ? SEL_NEXT_INS : pending;
        pending_next = pending_base;
        if (pulse_code > pending_base)
            pending_next = pulse_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= SEL_NEXT_INS;
            kill    <= 1'b0;
        end else begin
            pending <= pending_next;
            if (state == ST_WAIT && imem_rvalid)
                kill <= 1'b0;
            else if (redirect_now && (state == ST_WAIT || (state == ST_REQ && imem_gnt)))
                kill <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Architectural PC register and REQ/WAIT/HOLD fetch FSM feeding decode;
// redirect handling lives in the redirect arbiter.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     next_pc,
    output logic [31:0]     pc_add4,
    output logic [1:0]      pc_sel,
    output logic [31:0]     pc,
    input  logic            redir_zero,
    input  logic            redir_jump,
    input  logic            redir_branch,
    fetch_pc_ctrl_if.master bus
);

    logic [1:0] state;
    logic       accept;
    logic       redirect_now;
    logic       kill;

    assign accept        = (state == ST_HOLD) && bus.instr_ready;
    assign pc_add4       = pc + 32'd4;
    assign bus.imem_addr = pc;
    assign bus.imem_req  = (state == ST_REQ) && !rst;

    fetch_pc_ctrl_redirect_arbiter u_arbiter (
        .clk          (clk),
        .rst          (rst),
        .redir_zero   (redir_zero),
        .redir_jump   (redir_jump),
        .redir_branch (redir_branch),
        .state        (state),
        .imem_gnt     (bus.imem_gnt),
        .imem_rvalid  (bus.imem_rvalid),
        .accept       (accept),
        .pc_sel       (pc_sel),
        .redirect_now (redirect_now),
        .kill         (kill)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_REQ;
            pc              <= RESET_PC;
            bus.instr_valid <= 1'b0;
            bus.instr       <= 32'd0;
            bus.instr_pc    <= 32'd0;
        end else begin
            if (accept || redirect_now)
                pc <= next_pc;

            case (state)
                ST_REQ: begin
                    if (bus.imem_gnt)
                        state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.imem_rvalid) begin
                        // A redirect applied this cycle also makes the response stale.
                        if (kill || redirect_now) begin
                            state <= ST_REQ;
                        end else begin
                            bus.instr       <= bus.imem_rdata;
                            bus.instr_pc    <= pc;
                            bus.instr_valid <= 1'b1;
                            state           <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.instr_ready) begin
                        bus.instr_valid <= 1'b0;
                        state           <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

endmodule
